// File: rtl/dm_cache_ctrl.sv
`timescale 1ns/1ps
// Direct-mapped read cache controller: drives an external valid/tag/data array and refills it from main memory on a miss.
// Latency: hit returns cpu_ready two edges after the request is sampled; a miss adds the memory round trip.
// Backpressure: the CPU holds cpu_req until cpu_ready; memory is stalled by a level mem_req held until mem_ack.
module dm_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = ADDR_W - 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              flush,
    output logic              flush_busy,
    output logic [3:0]        arr_index,
    output logic              arr_wen,
    output logic              valid_wdata,
    output logic [TAG_W-1:0]  tag_wdata,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              valid_rdata,
    input  logic [TAG_W-1:0]  tag_rdata,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       miss_count
);

    localparam logic [1:0] S_FLUSH  = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_LOOKUP = 2'd2;
    localparam logic [1:0] S_MISS   = 2'd3;

    logic [1:0]       state;
    logic [3:0]       flush_idx;
    logic [3:0]       lat_index;
    logic [TAG_W-1:0] lat_tag;
    logic             hit;
    logic             addr_unused;

    // Byte offset within the word never reaches the arrays or memory.
    assign addr_unused = ^cpu_addr[1:0];

    assign hit        = valid_rdata && (tag_rdata == lat_tag);
    assign flush_busy = rst || (state == S_FLUSH);

    // Control state, request latch, CPU response and memory request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FLUSH;
            flush_idx  <= 4'd0;
            lat_index  <= 4'd0;
            lat_tag    <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            miss_count <= 16'd0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                S_FLUSH: begin
                    flush_idx <= flush_idx + 4'd1;
                    if (flush_idx == 4'd15) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    // Flush wins over a simultaneous read; the read is served after the sweep.
                    if (flush) begin
                        state     <= S_FLUSH;
                        flush_idx <= 4'd0;
                    end else if (cpu_req) begin
                        lat_index <= cpu_addr[5:2];
                        lat_tag   <= cpu_addr[ADDR_W-1:6];
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        cpu_rdata <= data_rdata;
                        cpu_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        miss_count <= miss_count + 16'd1;
                        mem_req    <= 1'b1;
                        mem_addr   <= {lat_tag, lat_index, 2'b00};
                        state      <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (mem_ack) begin
                        cpu_rdata <= mem_rdata;
                        cpu_ready <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_FLUSH;
            endcase
        end
    end

    // Array port: sweep writes during flush, refill write on the ack cycle, otherwise read-only.
    always_comb begin
        arr_index   = lat_index;
        arr_wen     = 1'b0;
        valid_wdata = 1'b0;
        tag_wdata   = '0;
        data_wdata  = '0;
        if (!rst) begin
            case (state)
                S_FLUSH: begin
                    arr_index = flush_idx;
                    arr_wen   = 1'b1;
                end
                S_MISS: begin
                    if (mem_ack) begin
                        arr_wen     = 1'b1;
                        valid_wdata = 1'b1;
                        tag_wdata   = lat_tag;
                        data_wdata  = mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
`timescale 1ns/1ps
// Directed bench for dm_cache_ctrl with a behavioural 16-entry valid/tag/data array.
module tb_dm_cache_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = ADDR_W - 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              flush;
    logic              flush_busy;
    logic [3:0]        arr_index;
    logic              arr_wen;
    logic              valid_wdata;
    logic [TAG_W-1:0]  tag_wdata;
    logic [DATA_W-1:0] data_wdata;
    logic              valid_rdata;
    logic [TAG_W-1:0]  tag_rdata;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       miss_count;

    int vec  = 0;
    int errs = 0;

    // Array model: asynchronous read, synchronous write, preloaded with junk.
    logic              model_init;
    logic [15:0]       m_valid;
    logic [TAG_W-1:0]  m_tag  [16];
    logic [DATA_W-1:0] m_data [16];

    always @(posedge clk) begin
        if (model_init) begin
            m_valid <= 16'hFFFF;
            for (int k = 0; k < 16; k++) begin
                m_tag[k]  <= TAG_W'(k + 5);
                m_data[k] <= DATA_W'(32'hA000_0000 + k);
            end
        end else if (arr_wen) begin
            m_valid[arr_index] <= valid_wdata;
            m_tag[arr_index]   <= tag_wdata;
            m_data[arr_index]  <= data_wdata;
        end
    end

    assign valid_rdata = m_valid[arr_index];
    assign tag_rdata   = m_tag[arr_index];
    assign data_rdata  = m_data[arr_index];

    always #5 clk = ~clk;

    dm_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .flush(flush), .flush_busy(flush_busy),
        .arr_index(arr_index), .arr_wen(arr_wen), .valid_wdata(valid_wdata),
        .tag_wdata(tag_wdata), .data_wdata(data_wdata),
        .valid_rdata(valid_rdata), .tag_rdata(tag_rdata), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .miss_count(miss_count)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        vec++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Read expected to miss: memory acks on the fourth mem_req cycle.
    task automatic miss_read(input logic [31:0] addr, input logic [31:0] exp_maddr,
                             input logic [3:0] exp_idx, input logic [TAG_W-1:0] exp_tag,
                             input logic [31:0] rd);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        step();
        chk("lookup_mem_req", mem_req, 0);
        chk("lookup_cpu_ready", cpu_ready, 0);
        step();
        chk("miss_mem_req", mem_req, 1);
        chk("miss_mem_addr", mem_addr, exp_maddr);
        step();
        chk("miss_mem_req_hold", mem_req, 1);
        step();
        chk("miss_mem_addr_hold", mem_addr, exp_maddr);
        step();
        mem_ack   = 1'b1;
        mem_rdata = rd;
        #1;
        chk("fill_wen", arr_wen, 1);
        chk("fill_index", arr_index, exp_idx);
        chk("fill_valid", valid_wdata, 1);
        chk("fill_tag", tag_wdata, exp_tag);
        chk("fill_data", data_wdata, rd);
        step();
        mem_ack = 1'b0;
        chk("miss_cpu_ready", cpu_ready, 1);
        chk("miss_cpu_rdata", cpu_rdata, rd);
        chk("miss_mem_req_drop", mem_req, 0);
        cpu_req = 1'b0;
        step();
        chk("miss_ready_pulse", cpu_ready, 0);
        chk("miss_rdata_hold", cpu_rdata, rd);
    endtask

    // Read expected to hit: cpu_ready two edges after the request is sampled.
    task automatic hit_read(input logic [31:0] addr, input logic [31:0] rd);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        step();
        chk("hit_lookup_ready", cpu_ready, 0);
        chk("hit_lookup_mem_req", mem_req, 0);
        step();
        chk("hit_cpu_ready", cpu_ready, 1);
        chk("hit_cpu_rdata", cpu_rdata, rd);
        chk("hit_no_mem_req", mem_req, 0);
        cpu_req = 1'b0;
        step();
        chk("hit_ready_pulse", cpu_ready, 0);
    endtask

    initial begin
        rst        = 1'b1;
        model_init = 1'b1;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;

        // Reset for two cycles.
        step();
        model_init = 1'b0;
        chk("rst_wen", arr_wen, 0);
        chk("rst_busy", flush_busy, 1);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_miss_count", miss_count, 0);
        step();
        chk("rst2_wen", arr_wen, 0);
        chk("rst2_busy", flush_busy, 1);
        rst = 1'b0;
        #1;

        // Power-on sweep: 16 writes of zero, index 0..15.
        for (int i = 0; i < 16; i++) begin
            chk("sweep_wen", arr_wen, 1);
            chk("sweep_index", arr_index, i);
            chk("sweep_valid", valid_wdata, 0);
            chk("sweep_busy", flush_busy, 1);
            step();
        end
        chk("sweep_done_busy", flush_busy, 0);
        chk("sweep_done_wen", arr_wen, 0);
        chk("sweep_valid_bits", m_valid, 16'h0000);

        // Cold miss on 0x40: index 0, tag 1.
        miss_read(32'h0000_0040, 32'h0000_0040, 4'd0, 26'd1, 32'hDEAD_BEEF);
        chk("fill_model_valid", m_valid[0], 1);
        chk("fill_model_tag", m_tag[0], 1);
        chk("miss_count_1", miss_count, 1);

        // Same address hits.
        hit_read(32'h0000_0040, 32'hDEAD_BEEF);
        chk("miss_count_hit", miss_count, 1);

        // Conflict miss on 0x80, then 0x40 misses again.
        miss_read(32'h0000_0080, 32'h0000_0080, 4'd0, 26'd2, 32'hCAFE_F00D);
        chk("conflict_model_tag", m_tag[0], 2);
        miss_read(32'h0000_0040, 32'h0000_0040, 4'd0, 26'd1, 32'h1234_5678);
        chk("miss_count_3", miss_count, 3);

        // Stray ack while idle changes nothing.
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        #1;
        chk("stray_ack_wen", arr_wen, 0);
        step();
        mem_ack = 1'b0;
        chk("stray_ack_ready", cpu_ready, 0);
        chk("stray_ack_rdata", cpu_rdata, 32'h1234_5678);

        // Flush and read together: sweep first, then the read misses.
        flush    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0044;
        step();
        flush = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("flush_wen", arr_wen, 1);
            chk("flush_index", arr_index, i);
            chk("flush_busy", flush_busy, 1);
            step();
        end
        chk("flush_done_busy", flush_busy, 0);
        chk("flush_valid_bits", m_valid, 16'h0000);
        chk("flush_no_ready", cpu_ready, 0);
        miss_read(32'h0000_0044, 32'h0000_0044, 4'd1, 26'd1, 32'h0BAD_CAFE);
        chk("miss_count_4", miss_count, 4);

        // Reset during an outstanding miss, ack arrives afterwards.
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0100;
        step();
        step();
        chk("abort_mem_req", mem_req, 1);
        rst     = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("abort_rst_wen", arr_wen, 0);
        step();
        chk("abort_mem_req_low", mem_req, 0);
        chk("abort_no_ready", cpu_ready, 0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hFEED_0001;
                #1;
            end
            if (i == 2) begin
                mem_ack = 1'b0;
                chk("abort_late_ready", cpu_ready, 0);
                chk("abort_late_mem_req", mem_req, 0);
            end
            chk("abort_sweep_wen", arr_wen, 1);
            chk("abort_sweep_index", arr_index, i);
            chk("abort_sweep_valid", valid_wdata, 0);
            chk("abort_sweep_data", data_wdata, 0);
            step();
        end
        chk("abort_done_busy", flush_busy, 0);
        chk("abort_valid_bits", m_valid, 16'h0000);
        chk("abort_miss_count", miss_count, 0);
        chk("abort_cpu_ready", cpu_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
